// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared motor command types and clamp helper
package motor_pkg;

    typedef struct packed {
        logic       dir;
        logic [6:0] mag;
    } motor_cmd_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Keep the direction bit, limit the magnitude to max_mag
    function automatic motor_cmd_t clamp_cmd(input logic [7:0] raw, input logic [6:0] max_mag);
        motor_cmd_t c;
        c.dir = raw[7];
        c.mag = (raw[6:0] > max_mag) ? max_mag : raw[6:0];
        return c;
    endfunction

endpackage

// File: rtl/motor_ramp.sv
// rtl/motor_ramp.sv - one slew-limited motor channel with reversal through zero
module motor_ramp
    import motor_pkg::*;
#(
    parameter logic [6:0] STEP = 7'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  motor_cmd_t tgt,
    output motor_cmd_t cur
);

    logic [7:0] cur_mag;
    logic [7:0] tgt_mag;
    logic [7:0] step_w;
    logic [7:0] diff;
    logic [7:0] toward;
    logic [7:0] to_zero;

    // Step sizes, computed in 8 bits so nothing wraps below 0 or above 127
    always_comb begin
        cur_mag = {1'b0, cur.mag};
        tgt_mag = {1'b0, tgt.mag};
        step_w  = {1'b0, STEP};
        diff    = (tgt_mag > cur_mag) ? (tgt_mag - cur_mag) : (cur_mag - tgt_mag);
        toward  = (diff < step_w) ? diff : step_w;
        to_zero = (cur_mag < step_w) ? cur_mag : step_w;
    end

    // On each tick move one step; a direction change only happens at magnitude 0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= '0;
        end else if (tick) begin
            if (cur.mag == 7'd0) begin
                cur.dir <= tgt.dir;
                cur.mag <= (tgt.mag < STEP) ? tgt.mag : STEP;
            end else if (cur.dir != tgt.dir) begin
                cur.mag <= 7'(cur_mag - to_zero);
            end else if (tgt_mag > cur_mag) begin
                cur.mag <= 7'(cur_mag + toward);
            end else begin
                cur.mag <= 7'(cur_mag - toward);
            end
        end
    end

endmodule

// File: rtl/motor_cmd_stage.sv
// rtl/motor_cmd_stage.sv - frame capture, clamp, watchdog and ramp for two motors
module motor_cmd_stage
    import motor_pkg::*;
#(
    parameter logic [15:0] RAMP_DIV   = 16'd59,
    parameter logic [6:0]  STEP       = 7'd4,
    parameter logic [6:0]  MAX_MAG    = 7'd127,
    parameter logic [15:0] WDOG_LIMIT = 16'd5880
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] motor1_raw,
    input  logic [7:0] motor2_raw,
    output logic [7:0] motor1,
    output logic [7:0] motor2,
    output logic       frame_pulse,
    output logic       cmd_timeout,
    output logic       at_target
);

    logic       load_s1;
    logic       load_s2;
    logic       load_prev;
    logic       capture;
    logic       tick;
    logic       expire;
    logic [15:0] pre_cnt;
    logic [15:0] wdog_cnt;
    motor_cmd_t tgt1;
    motor_cmd_t tgt2;
    motor_cmd_t cur1;
    motor_cmd_t cur2;

    assign capture = load_prev && !load_s2;
    assign tick    = (pre_cnt == RAMP_DIV - 16'd1);
    assign expire  = (wdog_cnt >= WDOG_LIMIT - 16'd1);

    // Bring the MCU load strobe into the clk domain and keep one more stage for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_s1   <= 1'b0;
            load_s2   <= 1'b0;
            load_prev <= 1'b0;
        end else begin
            load_s1   <= load;
            load_s2   <= load_s1;
            load_prev <= load_s2;
        end
    end

    // Free-running ramp prescaler
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
        end
    end

    // Capture targets at frame end; watchdog zeroes targets on expiry, capture takes priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt1        <= '0;
            tgt2        <= '0;
            wdog_cnt    <= '0;
            frame_pulse <= 1'b0;
            cmd_timeout <= 1'b1;
        end else begin
            frame_pulse <= capture;
            if (capture) begin
                tgt1        <= clamp_cmd(motor1_raw, MAX_MAG);
                tgt2        <= clamp_cmd(motor2_raw, MAX_MAG);
                wdog_cnt    <= '0;
                cmd_timeout <= 1'b0;
            end else if (expire) begin
                tgt1        <= '0;
                tgt2        <= '0;
                wdog_cnt    <= WDOG_LIMIT;
                cmd_timeout <= 1'b1;
            end else begin
                wdog_cnt    <= wdog_cnt + 16'd1;
            end
        end
    end

    motor_ramp #(.STEP(STEP)) u_ramp1 (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .tgt   (tgt1),
        .cur   (cur1)
    );

    motor_ramp #(.STEP(STEP)) u_ramp2 (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .tgt   (tgt2),
        .cur   (cur2)
    );

    assign motor1    = cur1;
    assign motor2    = cur2;
    assign at_target = (cur1 == tgt1) && (cur2 == tgt2);

endmodule
